// File: rtl/xc7_io_pkg.sv
// xc7_io_pkg
//   Shared constants for the xc7 example I/O blocks.
//   CLK_HZ                   : clock frequency assumed by the example tops.
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms of stable input at CLK_HZ.
//   DEBOUNCE_CNT_W_DEFAULT   : counter width that holds DEBOUNCE_CYCLES_DEFAULT-1.
package xc7_io_pkg;

    localparam int CLK_HZ                  = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
    localparam int DEBOUNCE_CNT_W_DEFAULT  = 20;

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
//   One input channel: two-flop synchroniser, stability counter, debounced
//   level and registered one-cycle press/release pulses.
//   Ports:
//     clki        in  system clock, rising edge
//     rst_n       in  asynchronous active-low reset
//     btn_in      in  raw pad level, asynchronous to clki
//     btn_state   out debounced level
//     btn_press   out one-cycle pulse on an accepted 0->1 change
//     btn_release out one-cycle pulse on an accepted 1->0 change
module debounce_chan
    import xc7_io_pkg::*;
#(
    parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clki,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release
);

    // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W))) begin : g_bad_cfg
        $error("debounce_chan: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Saturating increment; the caller never asks past CNT_MAX, so the
    // clamp is only a guard against wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX)
            return c;
        return c + 1'b1;
    endfunction

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            btn_state   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            // Synchroniser: only s2 is allowed to reach the debounce logic.
            s1          <= btn_in;
            s2          <= s1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            // Debounce: any sample agreeing with the current level restarts
            // the count, so only an unbroken run of DEBOUNCE_CYCLES differing
            // samples is accepted.
            if (s2 == btn_state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_state   <= s2;
                cnt         <= '0;
                btn_press   <= s2;
                btn_release <= ~s2;
            end else begin
                cnt <= cnt_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   Debounces N_BTN asynchronous push-button/switch pads into clean levels
//   plus one-cycle press/release pulses per channel.
//   Ports:
//     clki        in  system clock, rising edge
//     rst_n       in  asynchronous active-low reset
//     btn_in      in  [N_BTN] raw pad levels, active-high
//     btn_state   out [N_BTN] debounced levels
//     btn_press   out [N_BTN] one-cycle pulse on each accepted 0->1 change
//     btn_release out [N_BTN] one-cycle pulse on each accepted 1->0 change
//     any_press   out OR of btn_press, same cycle
module button_debounce
    import xc7_io_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clki        (clki),
            .rst_n       (rst_n),
            .btn_in      (btn_in[i]),
            .btn_state   (btn_state[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

    // Driven only by registered pulses, so no path from btn_in.
    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Directed and randomised bench for button_debounce with N_BTN=4,
//   CNT_W=4, DEBOUNCE_CYCLES=8 and a 10 ns clock.
module tb_button_debounce;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int D    = 8;
    localparam int NONE = 1000;

    logic         clki = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    int checks = 0;
    int errors = 0;

    always #5 clki = ~clki;

    button_debounce #(
        .N_BTN           (N),
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clki        (clki),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"},   btn_state,   '0);
        check({tag, "_press"},   btn_press,   '0);
        check({tag, "_release"}, btn_release, '0);
        check({tag, "_any"},     {3'b0, any_press}, '0);
    endtask

    // Runs n cycles with btn_in held; expects a press pulse (pmask) on cycle
    // press_at and a release pulse (rmask) on cycle rel_at, counted from the
    // first sampling edge after the call.
    task automatic run_expect(input string tag, input int n,
                              input int press_at, input logic [N-1:0] pmask,
                              input int rel_at,   input logic [N-1:0] rmask,
                              input logic [N-1:0] st0);
        logic [N-1:0] ep, er, es;
        for (int k = 1; k <= n; k++) begin
            tick();
            ep = (k == press_at) ? pmask : '0;
            er = (k == rel_at)   ? rmask : '0;
            es = st0;
            if (k >= press_at) es = es | pmask;
            if (k >= rel_at)   es = es & ~rmask;
            check({tag, "_press"},   btn_press,   ep);
            check({tag, "_release"}, btn_release, er);
            check({tag, "_state"},   btn_state,   es);
            check({tag, "_any"},     {3'b0, any_press}, {3'b0, |ep});
        end
    endtask

    initial begin
        logic [N-1:0] cur, h1, h2, mst, mp, mr, last_press, prev_p, prev_r;
        int           run [N];
        int           hold [N];

        // Reset held with all pads high: everything stays low.
        rst_n  = 1'b0;
        btn_in = 4'hF;
        tick();
        check_zero("rst_low0");
        tick();
        tick();
        check_zero("rst_low2");

        // Release: pads already high give a press on all channels at cycle 10.
        rst_n = 1'b1;
        run_expect("rst_hold", 12, 10, 4'hF, NONE, 4'h0, 4'h0);

        // All pads low: release on all channels at cycle 10.
        btn_in = 4'h0;
        run_expect("all_rel", 12, NONE, 4'h0, 10, 4'hF, 4'hF);

        // Channel 0 press alone.
        btn_in = 4'h1;
        run_expect("ch0_press", 12, 10, 4'h1, NONE, 4'h0, 4'h0);

        // Channel 1 bounce: 7 cycles high is one short, nothing happens.
        btn_in = 4'h3;
        run_expect("ch1_b7", 7, NONE, 4'h0, NONE, 4'h0, 4'h1);
        btn_in = 4'h1;
        run_expect("ch1_b7_low", 6, NONE, 4'h0, NONE, 4'h0, 4'h1);

        // Exactly 8 cycles high is accepted; press lands on edge 10, and the
        // fall that follows releases 10 edges after it was first sampled.
        btn_in = 4'h3;
        run_expect("ch1_h8", 8, NONE, 4'h0, NONE, 4'h0, 4'h1);
        btn_in = 4'h1;
        run_expect("ch1_h8_fall", 12, 2, 4'h2, 10, 4'h2, 4'h1);

        // Channel 2 press then release.
        btn_in = 4'h5;
        run_expect("ch2_press", 12, 10, 4'h4, NONE, 4'h0, 4'h1);
        btn_in = 4'h1;
        run_expect("ch2_rel", 12, NONE, 4'h0, 10, 4'h4, 4'h5);

        // Reset mid-debounce on channel 3: count is lost, everything restarts.
        btn_in = 4'h9;
        run_expect("ch3_pre", 5, NONE, 4'h0, NONE, 4'h0, 4'h1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst_async");
        tick();
        tick();
        check_zero("mid_rst_hold");
        rst_n = 1'b1;
        run_expect("ch3_post", 12, 10, 4'h9, NONE, 4'h0, 4'h0);

        // Randomised bounce against a run-length reference model.
        rst_n  = 1'b0;
        btn_in = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        cur = '0; h1 = '0; h2 = '0; mst = '0;
        last_press = '0; prev_p = '0; prev_r = '0;
        for (int i = 0; i < N; i++) begin
            run[i]  = 0;
            hold[i] = $urandom_range(1, 14);
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = $urandom_range(1, 14);
                end else begin
                    hold[i]--;
                end
            end
            btn_in = cur;
            tick();
            // The level seen by the debouncer at this edge was applied two
            // edges earlier; D consecutive differing samples flip the state.
            mp = '0;
            mr = '0;
            for (int i = 0; i < N; i++) begin
                if (h2[i] != mst[i]) begin
                    if (run[i] == D - 1) begin
                        mst[i] = h2[i];
                        mp[i]  = h2[i];
                        mr[i]  = ~h2[i];
                        run[i] = 0;
                    end else begin
                        run[i]++;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            h2 = h1;
            h1 = cur;
            check("rnd_state",   btn_state,   mst);
            check("rnd_press",   btn_press,   mp);
            check("rnd_release", btn_release, mr);
            check("rnd_any",     {3'b0, any_press}, {3'b0, |mp});
            check("rnd_both",    btn_press & btn_release, '0);
            check("rnd_long",    (btn_press & prev_p) | (btn_release & prev_r), '0);
            check("rnd_alt",     (btn_press & last_press) | (btn_release & ~last_press), '0);
            last_press = (last_press | btn_press) & ~btn_release;
            prev_p = btn_press;
            prev_r = btn_release;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
